// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, predecodes J for zero-bubble jumps,
// and buffers {pc, inst} pairs toward decode in a small circular FIFO.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic        pop;
  logic        push;
  logic        is_jump;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_next_pc;

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A same-cycle pop frees the slot, so a full buffer can still accept a fetch.
  assign push      = (state_q == StRun) & ~redirect_valid & ((count_q < DepthCnt) | pop);

  assign is_jump       = (imem_inst[31:26] == 6'b000010);
  assign pc_plus4      = pc_q + 32'd4;
  assign fetch_next_pc = is_jump ? {pc_plus4[31:28], imem_inst[25:0], 2'b00} : pc_plus4;

  assign out_inst = out_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign out_pc   = out_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign out_pc4  = out_valid ? (pc_mem[rd_ptr_q] + 32'd4) : 32'h0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      // Redirect flushes everything, including a J predecoded this cycle.
      state_d  = StRun;
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (state_q == StBoot) state_d = StRun;
      if (push) begin
        pc_d     = fetch_next_pc;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= imem_inst;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: queue-based reference model compared every
// cycle, plus directed literal checks from the test plan and a randomized phase.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 1;
  bit cmp_en   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_boot;

  fetch_sequencer #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_pc4       (out_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode 1: single J at 0x10 targeting field 6; mode 2: a J word every 32 bytes.
  function automatic logic [31:0] inst_at(input logic [31:0] addr, input int md);
    logic [25:0] fld;
    if (md == 1 && addr == 32'h10) return 32'h0800_0006;
    if (md == 2 && addr[4:2] == 3'd5) begin
      fld = addr[27:2] + 26'd7;
      return {6'b000010, fld};
    end
    return 32'h1000_0000 + addr;
  endfunction

  always_comb imem_inst = inst_at(imem_addr, mode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = RESET_PC;
    m_boot = 1'b1;
  endtask

  // One clock: the model advances from the inputs held across the edge.
  task automatic step();
    ent_t        e;
    logic [31:0] inst;
    @(posedge clk);
    if (rst_n) begin
      if (redirect_valid) begin
        q.delete();
        m_pc   = redirect_pc & 32'hFFFF_FFFC;
        m_boot = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (q.size() < DEPTH) begin
          inst   = inst_at(m_pc, mode);
          e.pc   = m_pc;
          e.inst = inst;
          q.push_back(e);
          if (inst[31:26] == 6'b000010)
            m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | {4'h0, inst[25:0], 2'b00};
          else
            m_pc = m_pc + 32'd4;
        end
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
      if (q.size() != 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_inst", out_inst, q[0].inst);
        chk("out_pc4", out_pc4, q[0].pc + 32'd4);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc4", out_pc4, 32'h0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_seq [6];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18};
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    model_reset();
    cmp_en = 1'b1;
    do_reset();

    // Boot cycle, then straight-line fetch with the J at 0x10 jumping to 0x18.
    step();
    chk("boot_no_valid", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("seq_out_pc", out_pc, exp_seq[i]);
      chk("seq_out_pc4", out_pc4, exp_seq[i] + 32'd4);
      if (i == 4) chk("j_word", out_inst, 32'h0800_0006);
    end

    // Backpressure: buffer fills, PC and head freeze.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("stall_head", out_pc, 32'h18);
    chk("stall_addr", imem_addr, 32'h20);
    out_ready = 1'b1;
    step(); chk("rel_pc0", out_pc, 32'h1C);
    step(); chk("rel_pc1", out_pc, 32'h20);
    step(); chk("rel_pc2", out_pc, 32'h24);

    // Redirect with two buffered entries: one bubble, then the aligned target.
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    step();
    chk("redir_bubble", {31'h0, out_valid}, 32'h0);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step();
    chk("redir_target", out_pc, 32'h40);
    chk("redir_inst", out_inst, 32'h1000_0040);

    // Redirect colliding with a fetched J and a pop.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_000C;
    step();
    redirect_valid = 1'b0;
    step();
    chk("pre_j_head", out_pc, 32'hC);
    chk("pre_j_addr", imem_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    chk("jcoll_empty", {31'h0, out_valid}, 32'h0);
    chk("jcoll_addr", imem_addr, 32'h100);
    redirect_valid = 1'b0;
    step();
    chk("jcoll_target", out_pc, 32'h100);

    // Wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", out_pc4, 32'h0);
    step();
    chk("wrap_next", out_pc, 32'h0);
    step();
    do_reset();

    // Randomized traffic with frequent jumps, redirects and rare resets.
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                                   : $urandom;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    redirect_valid = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the pipelined MIPS core.
- Owns the PC and drives the combinational instruction memory address.
- Buffers fetched {pc, inst} pairs in a small FIFO toward decode, using a valid/ready handshake.
- Predecodes J (opcode 000010) for a zero-bubble jump; accepts branch/exception redirects from EX.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DEPTH, 2, fetch-buffer entries (legal values 2 or 4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  instruction memory address; combinationally equal to the PC register.
- imem_inst  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  redirect request from EX (taken branch).
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 00.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pc4  out  32  head PC + 4, modulo 2^32.

Behaviour:
- Reset (async assert, synchronous release):
  - pc = RESET_PC, FIFO count = 0, state = BOOT.
  - out_valid = 0; out_inst, out_pc and out_pc4 read 0.
  - imem_addr = RESET_PC.
- States:
  - BOOT: one cycle, no fetch, then RUN unconditionally.
  - RUN: normal fetching.
- pop = out_valid & out_ready.
- can_fetch = state==RUN & !redirect_valid & (count<DEPTH | pop).
- Fetch cycle (can_fetch = 1):
  - Push {pc, imem_inst} at the tail.
  - If imem_inst[31:26]==6'b000010, next pc = {pc4[31:28], imem_inst[25:0], 2'b00}.
  - Otherwise next pc = pc + 4, wrapping at 32 bits (0xFFFFFFFC -> 0x00000000).
  - There is no delay slot. The J word itself is pushed; the next fetch is the target.
- Stall cycle (FIFO full, no pop):
  - pc holds and nothing is pushed.
  - imem_addr keeps presenting the held pc.
- Redirect cycle (redirect_valid = 1, any state including BOOT):
  - FIFO is flushed (count = 0) and pc = {redirect_pc[31:2], 2'b00}.
  - No push this cycle; state becomes RUN.
  - A pop in the same cycle is still considered consumed by decode.
  - Redirect overrides any jump predecode in that cycle.
  - The first target instruction is visible at out_valid 2 cycles after the redirect edge: one bubble.
- Push and pop in the same cycle:
  - Count is unchanged.
  - When count==DEPTH, a pop frees the slot for a same-cycle push.
- FIFO:
  - Circular buffer with rd/wr pointers mod DEPTH.
  - out_* are driven from the head entry, not registered separately.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Latency: an instruction fetched at edge N is presented on out_* after edge N; decode sees it in cycle N+1.
- Throughput: one instruction per cycle when out_ready stays 1.
- Reset asserted mid-operation: immediate return to the reset values above, including FIFO contents discarded.
- Count never exceeds DEPTH and never underflows; pop while empty is impossible because out_valid gates it.

Test Plan:
- Reset then out_ready=1, bench memory returns 32'h1000_0000+addr -> out_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles after BOOT; out_pc4 = out_pc+4; no gaps.
- J at 0x10 with field 26'h000006 -> out_pc sequence 0x8, 0xC, 0x10, 0x18 with no bubble; out_inst at 0x10 is the J word.
- out_ready=0 for 5 cycles from steady state -> count saturates at DEPTH; imem_addr is frozen at (last pushed pc)+4; head is stable. Release -> in-order delivery, no loss or duplication.
- redirect_valid with redirect_pc=0x0000_0042 while FIFO holds 2 entries -> out_valid=0 next cycle, then out_pc=0x40; the old entries never appear.
- Redirect in the same cycle as a fetched J and a pop -> redirect target wins; J target is never fetched; count=0 afterward.
- Redirect to 0xFFFF_FFFC -> next out_pc values are 0xFFFFFFFC then 0x00000000; out_pc4 of the first is 0x0. Reset asserted mid-stream -> out_valid=0 immediately and imem_addr=RESET_PC.
